p3_execute_writeback: RTL and testbench

Consumer end of the decode/register-read stage's output bundle. It executes the decoded instruction (ALU op, flags, branch resolution, load/store over a req/ack memory port) and drives the register-file write-back interface (writeflag/writetarget/writeval) that the decode stage consumes. Sits between decode and the register file / data memory in the SIMPLE 16-bit pipeline.

---
 rtl/simple_pkg.sv | 48 ++++
 rtl/simple_alu.sv | 80 ++++++++
 rtl/p3_execute_writeback.sv | 184 ++++++++++++++++++
 tb/tb_p3_execute_writeback.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE 16-bit pipeline execute/write-back stage.
package simple_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_OUT = 4'd13;

  // Branch conditions
  localparam logic [2:0] COND_BE  = 3'd0;
  localparam logic [2:0] COND_BLT = 3'd1;
  localparam logic [2:0] COND_BLE = 3'd2;
  localparam logic [2:0] COND_BNE = 3'd3;
  localparam logic [2:0] COND_AL  = 3'd4;

  // Memory access kinds
  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_LOAD  = 2'b01;
  localparam logic [1:0] MW_STORE = 2'b10;

  // Execute/write-back FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  // Bit positions inside the {S,Z,C,V} flag vector
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Arithmetic, logic and shift ops update flags; MOV/OUT do not.
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op <= OP_CMP) || ((op >= OP_SLL) && (op <= OP_SRA));
  endfunction

endpackage

// File: rtl/simple_alu.sv
// Combinational ALU: 16-bit result plus S/Z/C/V flags.
module simple_alu
  import simple_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic [16:0] wide;
  logic [3:0]  amt;
  logic [3:0]  lidx;
  logic [3:0]  ridx;
  logic [4:0]  rot_sh;
  logic        c;
  logic        v;

  // Shift amount and the index of the last bit shifted out each way.
  assign amt    = b[3:0];
  assign rot_sh = 5'd16 - {1'b0, amt};
  assign lidx   = rot_sh[3:0];
  assign ridx   = amt - 4'd1;

  // Result and carry/overflow selection by opcode.
  always_comb begin
    wide   = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[15:0];
        c      = wide[16];
        v      = (a[15] == b[15]) && (result[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        // bit 16 of the 17-bit difference is the borrow
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[15:0];
        c      = wide[16];
        v      = (a[15] != b[15]) && (result[15] != a[15]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV, OP_OUT: result = a;
      OP_SLL: begin
        result = a << amt;
        c      = (amt != 4'd0) && a[lidx];
      end
      OP_SLR: begin
        // rotate left; a shift by 16 on the right leg yields zero for amt=0
        result = (a << amt) | (a >> rot_sh);
        c      = (amt != 4'd0) && a[lidx];
      end
      OP_SRL: begin
        result = a >> amt;
        c      = (amt != 4'd0) && a[ridx];
      end
      OP_SRA: begin
        result = $signed(a) >>> amt;
        c      = (amt != 4'd0) && a[ridx];
      end
      default: result = '0;
    endcase
  end

  // Pack the flag vector.
  always_comb begin
    flags         = '0;
    flags[FLAG_S] = result[15];
    flags[FLAG_Z] = (result == 16'd0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/p3_execute_writeback.sv
// Execute and write-back stage: ALU, flags, branch resolution, req/ack
// memory access and register-file write-back.
// Handshake: a bundle transfers on a clock edge where in_valid and
// in_ready are both 1; in_ready is 1 only while the FSM is IDLE, and the
// bundle is held internally until the instruction retires.
module p3_execute_writeback
  import simple_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu1,
  input  logic [15:0] alu2,
  input  logic [3:0]  opcode,
  input  logic        writereg,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  regaddress,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  input  logic        isbranch,
  input  logic [2:0]  cond,
  input  logic [15:0] pc,
  input  logic        halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        writeflag,
  output logic [2:0]  writetarget,
  output logic [15:0] writeval,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic [3:0]  flags,
  output logic        out_valid,
  output logic [15:0] outport,
  output logic        mem_error,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state;
  logic [3:0]  op_q;
  logic [15:0] a1_q, a2_q, addr_q, sd_q, pc_q;
  logic        wr_q, br_q, abort_q;
  logic [1:0]  mw_q;
  logic [2:0]  rd_q, cond_q;
  logic [15:0] res_q, ld_q, outport_q;
  logic [3:0]  flags_q;
  logic [7:0]  tmr_q;
  logic        mem_error_q;

  logic [15:0] alu_res;
  logic [3:0]  alu_flags;
  logic        accept;
  logic        cond_hit;

  simple_alu u_alu (
    .op     (op_q),
    .a      (a1_q),
    .b      (a2_q),
    .result (alu_res),
    .flags  (alu_flags)
  );

  assign accept = in_valid && (state == ST_IDLE);

  // Main FSM plus the captured bundle and execution results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      addr_q      <= '0;
      sd_q        <= '0;
      pc_q        <= '0;
      wr_q        <= 1'b0;
      br_q        <= 1'b0;
      abort_q     <= 1'b0;
      mw_q        <= MW_NONE;
      rd_q        <= '0;
      cond_q      <= '0;
      res_q       <= '0;
      ld_q        <= '0;
      outport_q   <= '0;
      flags_q     <= '0;
      tmr_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= opcode;
            a1_q    <= alu1;
            a2_q    <= alu2;
            addr_q  <= address;
            sd_q    <= storedata;
            pc_q    <= pc;
            wr_q    <= writereg;
            br_q    <= isbranch;
            mw_q    <= memwrite;
            rd_q    <= regaddress;
            cond_q  <= cond;
            abort_q <= 1'b0;
            // outport changes on the same edge that starts EXEC so it is
            // already valid while out_valid pulses
            if (!halt && opcode == OP_OUT && !isbranch && memwrite == MW_NONE)
              outport_q <= alu1;
            state <= halt ? ST_HALTED : ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q <= alu_res;
          if (!br_q && mw_q == MW_NONE && op_sets_flags(op_q))
            flags_q <= alu_flags;
          if (br_q) begin
            state <= ST_WB;
          end else if (mw_q != MW_NONE) begin
            tmr_q <= '0;
            state <= ST_MEM;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (mw_q == MW_LOAD) ld_q <= mem_rdata;
            state <= ST_WB;
          end else if (tmr_q == TMO_LAST) begin
            abort_q     <= 1'b1;
            mem_error_q <= 1'b1;
            state       <= ST_WB;
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        ST_WB:     state <= ST_IDLE;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Branch condition on the flags held before this instruction.
  always_comb begin
    cond_hit = 1'b0;
    case (cond_q)
      COND_BE:  cond_hit = flags_q[FLAG_Z];
      COND_BLT: cond_hit = flags_q[FLAG_S] ^ flags_q[FLAG_V];
      COND_BLE: cond_hit = flags_q[FLAG_Z] | (flags_q[FLAG_S] ^ flags_q[FLAG_V]);
      COND_BNE: cond_hit = !flags_q[FLAG_Z];
      COND_AL:  cond_hit = 1'b1;
      default:  cond_hit = 1'b0;
    endcase
  end

  // Strobes are decoded from state so an async reset drops them at once.
  always_comb begin
    in_ready      = (state == ST_IDLE);
    mem_req       = (state == ST_MEM);
    mem_we        = (mw_q == MW_STORE);
    mem_addr      = addr_q;
    mem_wdata     = sd_q;
    writeflag     = (state == ST_WB) && wr_q && !abort_q && (op_q != OP_CMP);
    writetarget   = rd_q;
    writeval      = (mw_q == MW_LOAD) ? ld_q : res_q;
    branch_taken  = (state == ST_EXEC) && br_q && cond_hit;
    branch_target = pc_q + addr_q;
    flags         = flags_q;
    out_valid     = (state == ST_EXEC) && (op_q == OP_OUT) && !br_q && (mw_q == MW_NONE);
    outport       = outport_q;
    mem_error     = mem_error_q;
    halted        = (state == ST_HALTED);
    dbg_state     = state;
  end

endmodule

// File: tb/tb_p3_execute_writeback.sv
// Self-checking bench for p3_execute_writeback: write-backs are scored
// against an expected queue, everything else is checked in line.
module tb_p3_execute_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu1 = '0, alu2 = '0, address = '0, storedata = '0, pc = '0;
  logic [3:0]  opcode = '0;
  logic        writereg = 1'b0, isbranch = 1'b0, halt = 1'b0;
  logic [1:0]  memwrite = '0;
  logic [2:0]  regaddress = '0, cond = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        writeflag;
  logic [2:0]  writetarget;
  logic [15:0] writeval;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [3:0]  flags;
  logic        out_valid;
  logic [15:0] outport;
  logic        mem_error, halted;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];

  p3_execute_writeback #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu1(alu1), .alu2(alu2), .opcode(opcode), .writereg(writereg),
    .memwrite(memwrite), .regaddress(regaddress), .address(address),
    .storedata(storedata), .isbranch(isbranch), .cond(cond), .pc(pc),
    .halt(halt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .writeflag(writeflag), .writetarget(writetarget), .writeval(writeval),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flags(flags), .out_valid(out_valid), .outport(outport),
    .mem_error(mem_error), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write-back strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && writeflag) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {13'd0, writetarget, writeval}, 32'h0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("wb_target", writetarget, e[18:16]);
        check("wb_value", writeval, e[15:0]);
      end
    end
  end

  // Reference results for the ops used in the random sweep.
  function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a, b,
                                  output logic [15:0] r, output logic [3:0] f);
    logic [16:0] w;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; w = '0;
    case (op)
      4'd0: begin w = a + b; r = w[15:0]; c = w[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = (a < b);
                  v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      default: r = a ^ b;
    endcase
    f = {r[15], (r == 16'd0), c, v};
  endfunction

  // Driver: wait for in_ready (bounded), present the bundle for one edge.
  task automatic send();
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a1, a2,
                       input logic wr, input logic [1:0] mw, input logic [2:0] rd,
                       input logic [15:0] addr, sd, input logic br,
                       input logic [2:0] cnd, input logic [15:0] pcv, input logic hlt);
    opcode = op; alu1 = a1; alu2 = a2; writereg = wr; memwrite = mw;
    regaddress = rd; address = addr; storedata = sd; isbranch = br;
    cond = cnd; pc = pcv; halt = hlt;
    send();
  endtask

  initial begin
    int cnt;
    logic [15:0] ra, rb, rr;
    logic [3:0] rop, rf;
    logic [2:0] rrd;

    // Reset
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_writeflag", writeflag, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_flags", flags, 0);
    check("rst_halted", halted, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;

    // ADD overflow into sign bit: write-back two cycles after accept
    exp_q.push_back({3'd3, 16'h8000});
    issue(4'd0, 16'h7FFF, 16'h0001, 1, 2'b00, 3'd3, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("add_exec_no_wb", writeflag, 0);
    @(negedge clock);
    check("add_wb_t2", writeflag, 1);
    check("add_flags", flags, 4'b1001);

    // CMP 5,5 then BE backwards
    issue(4'd5, 16'd5, 16'd5, 1, 2'b00, 3'd1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("cmp_flags", flags, 4'b0100);
    issue(4'd0, 0, 0, 0, 2'b00, 3'd0, 16'hFFFE, 0, 1, 3'd0, 16'h0010, 0);
    @(negedge clock);
    check("be_taken", branch_taken, 1);
    check("be_target", branch_target, 16'h000E);
    @(negedge clock);
    check("be_pulse_end", branch_taken, 0);
    check("be_flags_kept", flags, 4'b0100);

    // BNE on Z=1 must not be taken
    issue(4'd0, 0, 0, 0, 2'b00, 3'd0, 16'h0004, 0, 1, 3'd3, 16'h0020, 0);
    @(negedge clock);
    check("bne_not_taken", branch_taken, 0);

    // Load with ack in the third request cycle
    exp_q.push_back({3'd5, 16'hBEEF});
    issue(4'd0, 0, 0, 1, 2'b01, 3'd5, 16'h0040, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("ld_exec_no_req", mem_req, 0);
    @(negedge clock);
    check("ld_req_c1", mem_req, 1);
    check("ld_addr", mem_addr, 16'h0040);
    check("ld_we", mem_we, 0);
    @(negedge clock);
    check("ld_req_c2", mem_req, 1);
    @(negedge clock);
    check("ld_req_c3", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(posedge clock);
    #1 mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clock);
    check("ld_req_dropped", mem_req, 0);
    check("ld_wb_after_ack", writeflag, 1);

    // Store with no ack: abort after the timeout
    issue(4'd0, 0, 0, 1, 2'b10, 3'd6, 16'h0080, 16'h1234, 0, 0, 0, 0);
    @(negedge clock);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (mem_req) begin
        if (cnt == 0) begin
          check("st_we", mem_we, 1);
          check("st_wdata", mem_wdata, 16'h1234);
        end
        cnt++;
      end
    end
    check("st_req_cycles", cnt, 4);
    check("st_mem_error", mem_error, 1);
    check("st_in_ready", in_ready, 1);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_idle", dbg_state, 0);

    // OUT
    issue(4'd13, 16'hABCD, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("out_valid", out_valid, 1);
    check("outport", outport, 16'hABCD);
    @(negedge clock);
    check("out_pulse_end", out_valid, 0);
    check("out_flags_kept", flags, 4'b0100);

    // Shifts and subtraction boundaries
    exp_q.push_back({3'd2, 16'hC000});
    issue(4'd11, 16'h8001, 16'd1, 1, 2'b00, 3'd2, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("sra_flags", flags, 4'b1010);
    exp_q.push_back({3'd4, 16'h0003});
    issue(4'd9, 16'h8001, 16'd1, 1, 2'b00, 3'd4, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("slr_flags", flags, 4'b0010);
    exp_q.push_back({3'd7, 16'h0001});
    issue(4'd8, 16'h0001, 16'h0010, 1, 2'b00, 3'd7, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("sll0_flags", flags, 4'b0000);
    exp_q.push_back({3'd6, 16'hFFFF});
    issue(4'd1, 16'h0000, 16'h0001, 1, 2'b00, 3'd6, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("sub_borrow_flags", flags, 4'b1010);

    // Random arithmetic/logic sweep
    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(0, 4));
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rrd = 3'($urandom_range(0, 7));
      ref_alu(rop, ra, rb, rr, rf);
      exp_q.push_back({rrd, rr});
      issue(rop, ra, rb, 1, 2'b00, rrd, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      check("rand_flags", flags, rf);
    end

    // Halt is absorbing
    issue(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    check("halted", halted, 1);
    check("halt_in_ready", in_ready, 0);
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("halt_stays", dbg_state, 3'd4);
    check("halt_ready_low", in_ready, 0);
    in_valid = 1'b0;

    // Reset out of halt, then reset in the middle of a load
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    issue(4'd0, 0, 0, 1, 2'b01, 3'd1, 16'h0050, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    check("mid_ld_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_error", mem_error, 0);
    check("rst_mid_outport", outport, 0);
    check("rst_mid_flags", flags, 0);
    check("rst_mid_halted", halted, 0);
    check("rst_mid_addr", mem_addr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mid_no_wb", writeflag, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
